// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle byte-writable data memory responder for the RV32 load/store port
//
// Purpose:
//   Target end of the core's data-memory port. It accepts one request in IDLE,
//   waits LATENCY cycles, performs the array access, then presents a registered
//   response. Only one request is outstanding at a time.
//
// Ports:
//   clk_i         rising-edge clock
//   rst_ni        asynchronous active-low reset
//   req_valid_i   request present
//   req_ready_o   block can accept a request (IDLE only)
//   req_addr_i    byte address
//   req_we_i      1 = write, 0 = read
//   req_wdata_i   write data, lane i = bits [8i+7:8i]
//   req_be_i      byte enables, writes only
//   resp_valid_o  response present
//   resp_ready_i  requester takes the response
//   resp_rdata_o  read data; 0 for writes and errors
//   resp_err_o    request faulted (misaligned or out of range)

module data_mem_responder #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int LATENCY    = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] req_addr_i,
  input  logic             req_we_i,
  input  logic [WIDTH-1:0] req_wdata_i,
  input  logic [3:0]       req_be_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] resp_rdata_o,
  output logic             resp_err_o
);

  localparam int WORDS = 2 ** (ADDR_WIDTH - 2);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic             resp_err_q, resp_err_d;

  // Data array; deliberately not reset so preloaded contents survive rst_ni.
  logic [WIDTH-1:0] mem_q [WORDS];

  logic                  access;
  logic                  addr_err;
  logic                  mem_we;
  logic [ADDR_WIDTH-3:0] word_idx;

  // All access decisions use the latched request, never the live req_* inputs.
  assign access   = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[WIDTH-1:ADDR_WIDTH] != '0);
  assign word_idx = addr_q[ADDR_WIDTH-1:2];
  assign mem_we   = access && we_q && !addr_err;

  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          we_d    = req_we_i;
          wdata_d = req_wdata_i;
          be_d    = req_be_i;
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = addr_err;
          // Reads return the whole word regardless of be; writes and faults return 0.
          resp_rdata_d = (addr_err || we_q) ? '0 : mem_q[word_idx];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        // rdata/err are left holding; only valid drops on consumption.
        if (resp_ready_i) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      be_q         <= 4'b0000;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Byte-lane write port. While rst_ni is low the FSM sits in IDLE, so an
  // in-flight write that has not reached its access edge is dropped.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem_q[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder

module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n      [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic [31:0] req_addr   [3];
  logic        req_we     [3];
  logic [31:0] req_wdata  [3];
  logic [3:0]  req_be     [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];

  int npass  = 0;
  int nfail  = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  // Instance 0: LATENCY=2, instance 1: LATENCY=1, instance 2: LATENCY=15.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder #(
      .WIDTH     (32),
      .ADDR_WIDTH(17),
      .LATENCY   ((g == 0) ? 2 : ((g == 1) ? 1 : 15))
    ) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n[g]),
      .req_valid_i (req_valid[g]),
      .req_ready_o (req_ready[g]),
      .req_addr_i  (req_addr[g]),
      .req_we_i    (req_we[g]),
      .req_wdata_i (req_wdata[g]),
      .req_be_i    (req_be[g]),
      .resp_valid_o(resp_valid[g]),
      .resp_ready_i(resp_ready[g]),
      .resp_rdata_o(resp_rdata[g]),
      .resp_err_o  (resp_err[g])
    );
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no completion, expected finish before timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for resp_valid on instance d; returns cycles waited, 0 on timeout.
  task automatic wait_resp(input int d, output int lat);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (resp_valid[d] === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  // One full transaction with resp_ready held high; checks latency, rdata and err.
  task automatic txn(input int d, input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] be, input int exp_lat,
                     input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    chk({tag, ".req_ready"}, 32'(req_ready[d]), 32'd1);
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_addr[d]   = addr;
    req_wdata[d]  = wd;
    req_be[d]     = be;
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    wait_resp(d, lat);
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".rdata"}, resp_rdata[d], exp_rd);
    chk({tag, ".err"}, 32'(resp_err[d]), 32'(exp_err));
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 3; i++) begin
      rst_n[i]      = 1'b0;
      req_valid[i]  = 1'b0;
      req_addr[i]   = 32'h0;
      req_we[i]     = 1'b0;
      req_wdata[i]  = 32'h0;
      req_be[i]     = 4'h0;
      resp_ready[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    @(posedge clk); #1;

    chk("rst.req_ready", 32'(req_ready[0]), 32'd1);
    chk("rst.resp_valid", 32'(resp_valid[0]), 32'd0);
    chk("rst.resp_rdata", resp_rdata[0], 32'h0);
    chk("rst.resp_err", 32'(resp_err[0]), 32'd0);

    // Full word write then read back.
    txn(0, "wr_full", 1'b1, 32'h100, 32'hDEADBEEF, 4'b1111, 2, 32'h0, 1'b0);
    txn(0, "rd_full", 1'b0, 32'h100, 32'h0, 4'b0000, 2, 32'hDEADBEEF, 1'b0);

    // Byte lane 1 write merges into the existing word.
    txn(0, "wr_lane1", 1'b1, 32'h100, 32'h0000AA00, 4'b0010, 2, 32'h0, 1'b0);
    txn(0, "rd_lane1", 1'b0, 32'h100, 32'h0, 4'b1111, 2, 32'hDEADAAEF, 1'b0);

    // be=0000 write is a legal no-op.
    txn(0, "wr_be0", 1'b1, 32'h100, 32'hFFFFFFFF, 4'b0000, 2, 32'h0, 1'b0);
    txn(0, "rd_be0", 1'b0, 32'h100, 32'h0, 4'b0000, 2, 32'hDEADAAEF, 1'b0);

    // Faults: misaligned, out of range, and faulting writes that must not land.
    txn(0, "rd_mis", 1'b0, 32'h102, 32'h0, 4'b0000, 2, 32'h0, 1'b1);
    txn(0, "rd_oor", 1'b0, 32'h20000, 32'h0, 4'b0000, 2, 32'h0, 1'b1);
    txn(0, "wr_oor", 1'b1, 32'h20100, 32'h55555555, 4'b1111, 2, 32'h0, 1'b1);
    txn(0, "wr_mis", 1'b1, 32'h101, 32'h66666666, 4'b1111, 2, 32'h0, 1'b1);
    txn(0, "rd_after_err", 1'b0, 32'h100, 32'h0, 4'b0000, 2, 32'hDEADAAEF, 1'b0);

    // Backpressure: response held 5 cycles while a new request is waiting.
    req_valid[0]  = 1'b1;
    req_we[0]     = 1'b0;
    req_addr[0]   = 32'h100;
    req_be[0]     = 4'b0000;
    resp_ready[0] = 1'b0;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_resp(0, lat);
    chk("bp.lat", 32'(lat), 32'd2);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h200;
    req_wdata[0] = 32'h12345678;
    req_be[0]    = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.resp_valid", 32'(resp_valid[0]), 32'd1);
      chk("bp.resp_rdata", resp_rdata[0], 32'hDEADAAEF);
      chk("bp.resp_err", 32'(resp_err[0]), 32'd0);
      chk("bp.req_ready", 32'(req_ready[0]), 32'd0);
    end
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp.release_valid", 32'(resp_valid[0]), 32'd0);
    chk("bp.release_ready", 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("bp.pending_taken", 32'(req_ready[0]), 32'd0);
    wait_resp(0, lat);
    chk("bp.pending_lat", 32'(lat), 32'd2);
    chk("bp.pending_err", 32'(resp_err[0]), 32'd0);
    chk("bp.pending_rdata", resp_rdata[0], 32'h0);
    @(posedge clk); #1;
    txn(0, "rd_100_after_bp", 1'b0, 32'h100, 32'h0, 4'b0000, 2, 32'hDEADAAEF, 1'b0);
    txn(0, "rd_200_after_bp", 1'b0, 32'h200, 32'h0, 4'b0000, 2, 32'h12345678, 1'b0);

    // Asynchronous reset during WAIT of a write drops that write.
    req_valid[0]  = 1'b1;
    req_we[0]     = 1'b1;
    req_addr[0]   = 32'h200;
    req_wdata[0]  = 32'hCAFEF00D;
    req_be[0]     = 4'b1111;
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("arst.in_wait", 32'(req_ready[0]), 32'd0);
    #2;
    rst_n[0] = 1'b0;
    #1;
    chk("arst.req_ready", 32'(req_ready[0]), 32'd1);
    chk("arst.resp_valid", 32'(resp_valid[0]), 32'd0);
    chk("arst.resp_rdata", resp_rdata[0], 32'h0);
    chk("arst.resp_err", 32'(resp_err[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    @(posedge clk); #1;
    txn(0, "rd_200_after_rst", 1'b0, 32'h200, 32'h0, 4'b0000, 2, 32'h12345678, 1'b0);

    // LATENCY=1 instance.
    txn(1, "l1.wr", 1'b1, 32'h40, 32'hA5A50F0F, 4'b1111, 1, 32'h0, 1'b0);
    txn(1, "l1.wr_lane2", 1'b1, 32'h40, 32'h00770000, 4'b0100, 1, 32'h0, 1'b0);
    txn(1, "l1.rd", 1'b0, 32'h40, 32'h0, 4'b0000, 1, 32'hA5770F0F, 1'b0);
    txn(1, "l1.rd_oor", 1'b0, 32'h20000, 32'h0, 4'b0000, 1, 32'h0, 1'b1);

    // LATENCY=15 instance.
    txn(2, "l15.wr", 1'b1, 32'h40, 32'h01234567, 4'b1111, 15, 32'h0, 1'b0);
    txn(2, "l15.wr_lane3", 1'b1, 32'h40, 32'hEE000000, 4'b1000, 15, 32'h0, 1'b0);
    txn(2, "l15.rd", 1'b0, 32'h40, 32'h0, 4'b0000, 15, 32'hEE234567, 1'b0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
